// File: rtl/cl_burst_adapter.sv
// cl_burst_adapter: turns one cacheline refill/write-back request from the L1
// into a burst of s_line/s_burst beats toward physical memory.
// Optional watchdog: define CL_ADAPTER_TIMEOUT_EN to add the err_o port and end a
// burst that sees no memory acknowledge for 255 cycles.
module cl_burst_adapter #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
`ifdef CL_ADAPTER_TIMEOUT_EN
  ,
  output logic               err_o
`endif
);

  localparam int beats = s_line / s_burst;
  localparam int cw    = $clog2(beats);
  localparam int ob    = $clog2(s_line / 8);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t            state, state_n;
  logic [cw-1:0]     count;
  logic [s_line-1:0] wline;
  logic [31-ob:0]    addr_hi;
  logic              last;

`ifdef CL_ADAPTER_TIMEOUT_EN
  logic [7:0] wdog;
  logic       err_q;
  logic       expire;
  // a stalled burst is abandoned on its 255th cycle without an acknowledge
  assign expire = !resp_i && (wdog == 8'd254);
  assign err_o  = (state == DONE) && err_q;
`endif

  assign last      = resp_i && (count == cw'(beats - 1));
  assign address_o = {addr_hi, {ob{1'b0}}};
  assign read_o    = (state == RD);
  assign write_o   = (state == WR);
  assign resp_o    = (state == DONE);

  // state register; reset also aborts any burst in flight
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // next-state: write-back wins over refill, DONE always returns to IDLE
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (write_i)     state_n = WR;
        else if (read_i) state_n = RD;
      end
      RD, WR: begin
        if (last) state_n = DONE;
`ifdef CL_ADAPTER_TIMEOUT_EN
        else if (expire) state_n = DONE;
`endif
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // request latching, beat counter and refill assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      wline   <= '0;
      addr_hi <= '0;
      line_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          count <= '0;
          if (write_i) begin
            wline   <= line_i;
            addr_hi <= address_i[31:ob];
          end else if (read_i) begin
            addr_hi <= address_i[31:ob];
          end
        end
        RD: if (resp_i) begin
          for (int b = 0; b < beats; b++)
            if (count == cw'(b)) line_o[b*s_burst +: s_burst] <= burst_i;
          count <= count + 1'b1;
        end
        WR: if (resp_i) count <= count + 1'b1;
        default: ;
      endcase
    end
  end

  // outgoing write beat is the latched line slice selected by count
  always_comb begin
    burst_o = '0;
    for (int b = 0; b < beats; b++)
      if (count == cw'(b)) burst_o = wline[b*s_burst +: s_burst];
  end

`ifdef CL_ADAPTER_TIMEOUT_EN
  // watchdog: counts silent burst cycles, remembers whether the burst expired
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog  <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wdog  <= '0;
          err_q <= 1'b0;
        end
        RD, WR: begin
          if (resp_i) wdog <= '0;
          else        wdog <= wdog + 8'd1;
          if (expire) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: doc/cl_burst_adapter.md
CL_BURST_ADAPTER -- requirements
Module: cl_burst_adapter

Interface
REQ-001 Parameter s_line, default 256, cacheline width in bits.
REQ-002 Parameter s_burst, default 64, physical-memory beat width in bits; beats = s_line/s_burst (4 by default).
REQ-003 clk  input  1  clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 line_i  input  s_line  cacheline from L1 cache for write-back.
REQ-006 line_o  output  s_line  assembled cacheline to L1 cache on refill.
REQ-007 address_i  input  32  line address from L1 cache.
REQ-008 read_i / write_i  input  1 each  line refill / write-back request from cache, held high until resp_o.
REQ-009 resp_o  output  1  one-cycle completion pulse to cache.
REQ-010 burst_i  input  s_burst  read beat from memory.
REQ-011 burst_o  output  s_burst  write beat to memory.
REQ-012 address_o  output  32  burst base address to memory.
REQ-013 read_o / write_o  output  1 each  burst request to memory, held until last beat.
REQ-014 resp_i  input  1  memory beat acknowledge; one beat per high cycle.

Function
REQ-015 States IDLE, RD, WR, DONE; reset state IDLE.
REQ-016 IDLE: write_i high -> latch line_i and address_i, go WR; else read_i high -> latch address_i, go RD; write_i wins when both high.
REQ-017 address_o = latched address with low log2(s_line/8) bits forced to zero, stable for whole burst.
REQ-018 RD: read_o=1; each cycle with resp_i=1 stores burst_i into beat slot count (slot 0 = bits [s_burst-1:0]) and increments count.
REQ-019 WR: write_o=1; burst_o = latched line slice at count; each resp_i=1 increments count.
REQ-020 count is 2-bit (log2 beats), cleared on entering RD/WR; on the resp_i cycle with count=beats-1 go DONE.
REQ-021 DONE: resp_o=1 for exactly one cycle, then IDLE unconditionally; requests are sampled again only in IDLE.
REQ-022 line_o holds the last assembled line until the next RD completes; changes only in RD.
REQ-023 resp_i in IDLE or DONE ignored; read_o and write_o never both high.
REQ-024 Minimum latency: request at cycle 0 with resp_i high every cycle -> resp_o at cycle 5.
REQ-025 read_i/write_i dropping mid-burst does not abort the burst.

Reset
REQ-026 rst high: state IDLE, count 0, read_o 0, write_o 0, resp_o 0, line_o 0, address_o 0, burst_o 0 at next edge.
REQ-027 rst mid-burst aborts immediately; no resp_o issued for the aborted request.

Configuration
REQ-028 Macro CL_ADAPTER_TIMEOUT_EN defined: 8-bit watchdog counts RD/WR cycles without resp_i, cleared on each resp_i; at 255 go DONE, pulse resp_o, and output err_o (1-bit) high with it.
REQ-029 Macro undefined: no watchdog, no err_o port; burst waits indefinitely for resp_i.

Verification
REQ-030 Refill: read_i, address_i=0x0000_1234, burst_i=0x11..,0x22..,0x33..,0x44.. on 4 consecutive resp_i -> address_o=0x0000_1220, line_o={0x44..,0x33..,0x22..,0x11..}, resp_o at cycle 5.
REQ-031 Write-back: write_i, line_i=256'hDDDD_CCCC_BBBB_AAAA (per-beat pattern) -> burst_o order AAAA,BBBB,CCCC,DDDD, write_o drops after 4th resp_i, single resp_o.
REQ-032 Stalled memory: resp_i high every other cycle -> 4 beats over 8 cycles, resp_o at cycle 9, count never skips.
REQ-033 read_i and write_i both high in IDLE -> WR taken, read_o stays 0.
REQ-034 rst asserted after 2nd read beat -> read_o 0 next cycle, no resp_o; following read completes normally.
REQ-035 With CL_ADAPTER_TIMEOUT_EN, resp_i held 0 -> resp_o and err_o pulse after 255 RD cycles, return to IDLE.
